// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - instruction-memory request/ready bus for the IF fetch controller
interface if_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    // Fetch controller side: issues requests, receives data.
    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    // Instruction-memory side.
    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch controller with skid buffer and redirect squash
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_select,
    input  logic [31:0]       pc_b,
    input  logic [31:0]       pc_r,
    input  logic [31:0]       pc_j,
    input  logic              stall,
    if_fetch_ctrl_if.master   imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic [31:0]       pc4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] pend, pend_n;
    logic [31:0] skid, skid_n;
    logic [31:0] skid_pc, skid_pc_n;

    logic        redirect;
    logic [31:0] tgt;
    logic        accept;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;

    assign redirect = (pc_select != 2'b00);
    assign accept   = !instr_valid || !stall;

    // Target mux uses the same encoding as the IF next-PC mux.
    always_comb begin
        case (pc_select)
            2'b01:   tgt = pc_b;
            2'b10:   tgt = pc_r;
            2'b11:   tgt = pc_j;
            default: tgt = fetch_pc;
        endcase
    end

    // Request is a pure state decode so it can never glitch mid-handshake.
    assign imem.req  = (state == REQ) || (state == DRAIN);
    assign imem.addr = fetch_pc;
    assign pc4       = pc + 32'd4;

    // Next-state, fetch address, skid/pend capture and delivery select.
    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        pend_n        = pend;
        skid_n        = skid;
        skid_pc_n     = skid_pc;
        deliver       = 1'b0;
        deliver_instr = imem.rdata;
        deliver_pc    = fetch_pc;
        case (state)
            IDLE: begin
                state_n = REQ;
                if (redirect) fetch_pc_n = tgt;
            end
            REQ: begin
                if (redirect) begin
                    // A response arriving with a redirect is wrong-path; drop it.
                    if (imem.ready) begin
                        fetch_pc_n = tgt;
                    end else begin
                        pend_n  = tgt;
                        state_n = DRAIN;
                    end
                end else if (imem.ready) begin
                    fetch_pc_n = fetch_pc + 32'd4;
                    if (accept) begin
                        deliver = 1'b1;
                    end else begin
                        skid_n    = imem.rdata;
                        skid_pc_n = fetch_pc;
                        state_n   = FULL;
                    end
                end
            end
            DRAIN: begin
                // Keep address stable until the stale request completes.
                if (redirect) pend_n = tgt;
                if (imem.ready) begin
                    fetch_pc_n = redirect ? tgt : pend;
                    state_n    = REQ;
                end
            end
            FULL: begin
                if (redirect) begin
                    fetch_pc_n = tgt;
                    state_n    = REQ;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = skid;
                    deliver_pc    = skid_pc;
                    state_n       = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state and fetch-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend     <= 32'd0;
            skid     <= 32'd0;
            skid_pc  <= 32'd0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            pend     <= pend_n;
            skid     <= skid_n;
            skid_pc  <= skid_pc_n;
        end
    end

    // IF/ID output register: flush beats stall-hold beats delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= 32'd0;
            pc          <= 32'd0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            instr_valid <= 1'b0;
        end else if (stall && instr_valid) begin
            instr_valid <= 1'b1;
        end else if (deliver) begin
            instr       <= deliver_instr;
            pc          <= deliver_pc;
            instr_valid <= 1'b1;
        end else begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl against a transaction-level model
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_select;
    logic [31:0] pc_b, pc_r, pc_j;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc4;

    if_fetch_ctrl_if imem_bus();

    if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_select   (pc_select),
        .pc_b        (pc_b),
        .pc_r        (pc_r),
        .pc_j        (pc_j),
        .stall       (stall),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc4         (pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: fetch pointer, optional "stale response to discard"
    // with its deferred target, a buffer of at most one held word, and the
    // IF/ID contents.
    typedef struct packed {
        logic [31:0] w;
        logic [31:0] p;
    } ent_t;

    bit          m_started;
    bit          m_discard;
    logic [31:0] m_pend;
    ent_t        m_buf[$];
    logic [31:0] m_fetch;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          redir;
        logic [31:0] t;
        bit          dv;
        logic [31:0] dw, dp;
        if (rst) begin
            m_started = 0;
            m_discard = 0;
            m_pend    = 32'd0;
            m_buf.delete();
            m_fetch   = RST_PC;
            m_valid   = 0;
            m_instr   = 32'd0;
            m_pc      = 32'd0;
            return;
        end
        redir = (pc_select != 2'b00);
        t  = (pc_select == 2'b01) ? pc_b : (pc_select == 2'b10) ? pc_r : pc_j;
        dv = 0;
        dw = 32'd0;
        dp = 32'd0;
        if (!m_started) begin
            m_started = 1;
            if (redir) m_fetch = t;
        end else if (m_buf.size() != 0) begin
            if (redir) begin
                m_buf.delete();
                m_fetch = t;
            end else if (!stall) begin
                dv = 1;
                dw = m_buf[0].w;
                dp = m_buf[0].p;
                m_buf.delete();
            end
        end else if (m_discard) begin
            if (redir) m_pend = t;
            if (imem_bus.ready) begin
                m_fetch   = redir ? t : m_pend;
                m_discard = 0;
            end
        end else if (redir) begin
            if (imem_bus.ready) m_fetch = t;
            else begin
                m_discard = 1;
                m_pend    = t;
            end
        end else if (imem_bus.ready) begin
            if (!m_valid || !stall) begin
                dv = 1;
                dw = imem_bus.rdata;
                dp = m_fetch;
            end else begin
                m_buf.push_back('{w: imem_bus.rdata, p: m_fetch});
            end
            m_fetch = m_fetch + 32'd4;
        end
        if (redir)                 m_valid = 0;
        else if (stall && m_valid) m_valid = 1;
        else if (dv) begin
            m_instr = dw;
            m_pc    = dp;
            m_valid = 1;
        end else                   m_valid = 0;
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic step(input bit r, input logic [1:0] sel, input logic [31:0] b,
                        input logic [31:0] rr, input logic [31:0] j, input bit st,
                        input bit rdy, input logic [31:0] rd);
        bit          hs_pend;
        logic [31:0] hs_addr;
        rst            = r;
        pc_select      = sel;
        pc_b           = b;
        pc_r           = rr;
        pc_j           = j;
        stall          = st;
        imem_bus.ready = rdy;
        imem_bus.rdata = rd;
        hs_pend = imem_bus.req && !rdy && !r;
        hs_addr = imem_bus.addr;
        @(posedge clk);
        model_step();
        #1;
        check("imem_req", {31'd0, imem_bus.req}, {31'd0, (m_started && m_buf.size() == 0)});
        check("imem_addr", imem_bus.addr, m_fetch);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("instr", instr, m_instr);
            check("pc", pc, m_pc);
            check("pc4", pc4, m_pc + 32'd4);
        end
        if (hs_pend) begin
            check("hs_req_held", {31'd0, imem_bus.req}, 32'd1);
            check("hs_addr_held", imem_bus.addr, hs_addr);
        end
    endtask

    task automatic seq(input bit st, input bit rdy, input logic [31:0] rd);
        step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, st, rdy, rd);
    endtask

    initial begin
        rst = 1'b1; pc_select = 2'b00; pc_b = 0; pc_r = 0; pc_j = 0; stall = 0;
        imem_bus.ready = 0; imem_bus.rdata = 0;
        #1;

        // Reset values
        step(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1'b1, 2'b00, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("rst_req", {31'd0, imem_bus.req}, 32'd0);
        check("rst_addr", imem_bus.addr, 32'h0000_0100);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_pc4", pc4, 32'd4);

        // Sequential zero-wait fetch
        seq(0, 1, 32'hAAAA_0000);
        check("seq_addr0", imem_bus.addr, 32'h100);
        check("seq_valid0", {31'd0, instr_valid}, 32'd0);
        seq(0, 1, 32'hAAAA_0100);
        check("seq_pc0", pc, 32'h100);
        check("seq_instr0", instr, 32'hAAAA_0100);
        check("seq_pc4_0", pc4, 32'h104);
        check("seq_addr1", imem_bus.addr, 32'h104);
        seq(0, 1, 32'hAAAA_0104);
        check("seq_pc1", pc, 32'h104);
        check("seq_addr2", imem_bus.addr, 32'h108);

        // Jump at steady state
        step(0, 2'b11, 0, 0, 32'h400, 0, 1, 32'hBAD0_0108);
        check("jmp_flush", {31'd0, instr_valid}, 32'd0);
        check("jmp_addr", imem_bus.addr, 32'h400);
        seq(0, 1, 32'hAAAA_0400);
        check("jmp_pc", pc, 32'h400);
        check("jmp_valid", {31'd0, instr_valid}, 32'd1);

        // Stall with a returning word goes to the skid buffer
        seq(1, 1, 32'hAAAA_0404);
        check("stall_req0", {31'd0, imem_bus.req}, 32'd0);
        check("stall_pc_hold", pc, 32'h400);
        seq(1, 1, 32'h1111_1111);
        seq(1, 1, 32'h2222_2222);
        check("stall_req2", {31'd0, imem_bus.req}, 32'd0);
        check("stall_instr_hold", instr, 32'hAAAA_0400);
        seq(0, 1, 32'h3333_3333);
        check("skid_pc", pc, 32'h404);
        check("skid_instr", instr, 32'hAAAA_0404);
        check("skid_next_addr", imem_bus.addr, 32'h408);
        check("skid_next_req", {31'd0, imem_bus.req}, 32'd1);

        // Branch while waiting: drain the stale request
        step(0, 2'b01, 32'h300, 0, 0, 0, 0, 32'h0);
        check("drain_addr0", imem_bus.addr, 32'h408);
        check("drain_flush", {31'd0, instr_valid}, 32'd0);
        seq(0, 0, 32'h0);
        check("drain_addr1", imem_bus.addr, 32'h408);
        seq(0, 1, 32'hBAD0_0408);
        check("drain_done_addr", imem_bus.addr, 32'h300);
        check("drain_no_stale", {31'd0, instr_valid}, 32'd0);
        seq(0, 1, 32'hAAAA_0300);
        check("br_pc", pc, 32'h300);

        // Register jump to the top of the address space, then wrap
        step(0, 2'b10, 0, 32'hFFFF_FFFC, 0, 0, 1, 32'h0);
        check("wrap_addr0", imem_bus.addr, 32'hFFFF_FFFC);
        seq(0, 1, 32'hAAAA_FFFC);
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0);
        check("wrap_addr1", imem_bus.addr, 32'h0);
        seq(0, 1, 32'hAAAA_0000);
        check("wrap_pc_zero", pc, 32'h0);

        // Reset during DRAIN
        step(0, 2'b11, 0, 0, 32'h500, 0, 0, 32'h0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 32'h0);
        check("rdrain_req", {31'd0, imem_bus.req}, 32'd0);
        check("rdrain_valid", {31'd0, instr_valid}, 32'd0);
        seq(0, 1, 32'h0);
        check("rdrain_addr", imem_bus.addr, 32'h100);
        check("rdrain_req1", {31'd0, imem_bus.req}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit          r;
            logic [1:0]  sel;
            logic [31:0] base;
            r    = ($urandom_range(0, 249) == 0);
            sel  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
            step(r, sel, base + 32'h4, base + 32'h8, base + 32'hC,
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
